// File: rtl/reg_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// Covers the writeback request payload, source indices and the scoreboard mask helper.
package reg_wb_scheduler_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned DATA_W     = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_LSU = 2'd1,
      WB_CSR = 2'd2
   } wb_src_e;

   // One-hot scoreboard mask for a register; x0 never gets a bit.
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] m;
      m       = '0;
      m[addr] = 1'b1;
      m[0]    = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/reg_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// The pointer moves one past the last winner; grants are suppressed while rstn is low.
module reg_wb_scheduler_rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] valid,
   output logic [N-1:0] grant
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic [PW-1:0] idx;

   // Scan from the pointer with wrap-around; the first valid requester wins.
   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      idx      = '0;
      if (rstn) begin
         for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if ((grant == '0) && valid[idx]) begin
               grant[idx] = 1'b1;
               ptr_next   = PW'((32'(idx) + 1) % N);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler: round-robin writeback arbitration,
// busy-register scoreboard, and RAW/WAW issue stall.
module reg_wb_scheduler
   import reg_wb_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned XLEN    = 32
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          flush,
   input  logic                          issue_valid,
   input  logic [REG_ADDR_W-1:0]         issue_rs1,
   input  logic [REG_ADDR_W-1:0]         issue_rs2,
   input  logic [REG_ADDR_W-1:0]         issue_rd,
   input  logic                          issue_rd_we,
   output logic                          issue_ready,
   output logic                          rf_r_enabled,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
   input  logic [NUM_SRC*XLEN-1:0]       src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic                          w_enable,
   output logic [REG_ADDR_W-1:0]         w_addr,
   output logic [XLEN-1:0]               w_data,
   output logic [NUM_REGS-1:0]           busy
);

   logic [NUM_SRC-1:0]  grant;
   wb_req_t             sel;
   logic [NUM_REGS-1:0] busy_next;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   reg_wb_scheduler_rr_arbiter #(
      .N (NUM_SRC)
   ) u_arb (
      .clk   (clk),
      .rstn  (rstn),
      .valid (src_valid),
      .grant (grant)
   );

   assign src_ready = grant;

   // Only the registered scoreboard is consulted; a same-cycle grant does not bypass.
   assign issue_ready  = rstn & ~busy[issue_rs1] & ~busy[issue_rs2]
                       & ~(issue_rd_we & busy[issue_rd]) & ~flush;
   assign rf_r_enabled = issue_valid & issue_ready;

   // Select the granted source's request.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            sel.valid = 1'b1;
            sel.addr  = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
            sel.data  = DATA_W'(src_data[i*XLEN +: XLEN]);
         end
      end
   end

   // A new issue to the same register outranks the retiring write; flush outranks both.
   always_comb begin
      set_mask  = '0;
      clr_mask  = '0;
      if (sel.valid) begin
         clr_mask = reg_mask(sel.addr);
      end
      if (rf_r_enabled && issue_rd_we) begin
         set_mask = reg_mask(issue_rd);
      end
      busy_next = (busy & ~clr_mask) | set_mask;
      if (flush) begin
         busy_next = '0;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy     <= '0;
         w_enable <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
      end else begin
         busy     <= busy_next;
         w_enable <= sel.valid && (sel.addr != '0);
         if (sel.valid) begin
            w_addr <= sel.addr;
            w_data <= XLEN'(sel.data);
         end
      end
   end

endmodule

// File: doc/reg_wb_scheduler.md
Name: reg_wb_scheduler

Overview:
- Controls the single write port of the integer register file and tracks which registers have writes outstanding (a scoreboard).
- Arbitrates round-robin among NUM_SRC writeback sources (ALU, load unit, CSR/mul-div) and drives the register file's write port.
- Stalls decode/issue on RAW and WAW hazards against in-flight writes, and drives the register file read enable.

Parameters:
- NUM_SRC, 3, number of writeback requesters.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; clears the scoreboard
- issue_valid  in  1  decode has an instruction ready to issue
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_rd_we  in  1  the instruction writes rd
- issue_ready  out  1  no hazard; issue accepted this cycle
- rf_r_enabled  out  1  register file read enable (= issue_valid & issue_ready)
- src_valid  in  NUM_SRC  writeback request, one bit per source
- src_addr  in  NUM_SRC*5  destination per source; source i uses bits [5i+4:5i]
- src_data  in  NUM_SRC*XLEN  result per source; source i uses slice i
- src_ready  out  NUM_SRC  one-hot grant; transfer happens when valid & ready
- w_enable  out  1  register file write enable
- w_addr  out  5  register file write address
- w_data  out  XLEN  register file write data
- busy  out  32  scoreboard (debug/verification)

Behaviour:
- Reset (rstn=0 at a clock edge):
  - busy=0, w_enable=0, w_addr=0, w_data=0, round-robin pointer=0.
  - src_ready=0, issue_ready=0 and rf_r_enabled=0 while rstn=0.
- Scoreboard:
  - busy[0] is hardwired to 0.
  - Set: on a clock edge where issue_valid & issue_ready & issue_rd_we & (issue_rd!=0), busy[issue_rd] becomes 1.
- issue_ready (combinational):
  - Equals !busy[rs1] & !busy[rs2] & !(issue_rd_we & busy[rd]) & !flush.
  - Only the registered busy vector is checked; there is no same-cycle bypass of a grant.
- Arbitration (combinational, in cycle N):
  - Grant the first src_valid bit at or after the pointer, scanning with wrap-around.
  - src_ready is one-hot and all zeros when no source is valid.
  - At most one grant per cycle.
  - At the edge after a grant, the pointer moves to (granted index + 1) mod NUM_SRC; with no grant it holds.
- Write port (registered; latency of one cycle from grant):
  - At the end of grant cycle N: w_enable <= (granted addr != 0), w_addr <= addr, w_data <= data.
  - At the same edge, busy[addr] is cleared.
  - In cycle N+1 the register file writes, and its internal forwarding serves reads issued in N+1.
  - With no grant, w_enable <= 0; w_addr and w_data hold their values.
- Simultaneous set and clear of the same register at one edge: the set wins, because a newer write is now pending.
- A grant with addr 0 is consumed, writes nothing, and leaves busy unchanged.
- A grant for a register that is not busy (stray write) is still written; busy stays 0.
- flush:
  - At the edge, busy <= 0, taking priority over sets and clears.
  - A grant in the flush cycle is still written.
  - The pointer is unchanged.
- Sources must hold src_valid/addr/data stable until they are granted; a source with valid=0 is never granted.
- Reset mid-operation: a pending grant is dropped and no write occurs; the scoreboard is lost.

Decomposition:
- Shared package (def.sv):
  - Constants REG_ADDR_W=5, NUM_REGS=32.
  - Typedef wb_req_t {valid, addr[4:0], data[31:0]}.
  - Source index enum WB_ALU=0, WB_LSU=1, WB_CSR=2.
- One sub-module: rr_arbiter, parameterised on N, with a valid vector in, a one-hot grant out, and an internal pointer.
- The scoreboard and write-port registers stay in the top level.

Test Plan:
- Reset, then issue rd=5 (rs1=rs2=0) -> issue_ready=1, busy=0x20. Issue rs1=5 -> issue_ready=0, rf_r_enabled=0 until source 0 writes addr 5, data 0xDEADBEEF. Next cycle: w_enable=1, w_addr=5, w_data=0xDEADBEEF, busy=0, issue_ready=1.
- All three sources valid every cycle with addrs 1/2/3 -> grants 0,1,2,0 on consecutive cycles; w_addr sequence 1,2,3,1.
- A grant for rd=7 clears busy[7] at the same edge that a new issue with rd=7 sets it -> busy[7]=1 afterwards; a later read of x7 stalls.
- Source writes addr 0 with data 0x1234 -> src_ready=1, next cycle w_enable=0, busy[0]=0.
- busy=0x0000_00F0, flush=1 with a simultaneous grant to addr 4 -> next cycle busy=0, w_enable=1, w_addr=4; issue_ready=0 during the flush cycle.
- rstn=0 asserted in a cycle where src_valid=3'b001 -> next cycle w_enable=0, busy=0, src_ready=0; after release, the pointer grants source 0 first.
